morse_decoder: RTL and testbench

- Downstream consumer of the Morse letter encoder's serial dot/dash output.
- Samples the serial line once per unit-time tick and measures mark and space run lengths.
- Classifies each mark as dot or dash, assembles up to 4 symbols, and on an inter-letter gap reports the decoded letter (A–H, 3-bit code, 000 = A) or an error.
- Used as an on-board loopback checker and as the receive half of a link.

---
 rtl/morse_pkg.sv | 56 +++++
 rtl/morse_decoder_lookup.sv | 36 +++
 rtl/morse_decoder.sv | 167 ++++++++++++++++
 tb/tb_morse_decoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: items shared by the Morse letter encoder and decoder.
//   - Letter codes LTR_A..LTR_H (A = 000 ... H = 111).
//   - Per-letter symbol count and symbol pattern. The last symbol is in bit 0,
//     and 1 means dash.
//   - Unit timing: DOT_UNITS, DASH_UNITS and LETTER_GAP_UNITS.
//   - FSM state encoding state_t.
package morse_pkg;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  // Symbol counts per letter.
  localparam logic [2:0] LEN_A = 3'd2;
  localparam logic [2:0] LEN_B = 3'd4;
  localparam logic [2:0] LEN_C = 3'd4;
  localparam logic [2:0] LEN_D = 3'd3;
  localparam logic [2:0] LEN_E = 3'd1;
  localparam logic [2:0] LEN_F = 3'd4;
  localparam logic [2:0] LEN_G = 3'd3;
  localparam logic [2:0] LEN_H = 3'd4;

  // Symbol patterns. The oldest symbol is the most significant used bit.
  localparam logic [3:0] PAT_A = 4'b0001;  // .-
  localparam logic [3:0] PAT_B = 4'b1000;  // -...
  localparam logic [3:0] PAT_C = 4'b1010;  // -.-.
  localparam logic [3:0] PAT_D = 4'b0100;  // -..
  localparam logic [3:0] PAT_E = 4'b0000;  // .
  localparam logic [3:0] PAT_F = 4'b0010;  // ..-.
  localparam logic [3:0] PAT_G = 4'b0110;  // --.
  localparam logic [3:0] PAT_H = 4'b0000;  // ....

  // Tables indexed by letter code.
  localparam logic [7:0][2:0] LETTER_LEN =
    {LEN_H, LEN_G, LEN_F, LEN_E, LEN_D, LEN_C, LEN_B, LEN_A};
  localparam logic [7:0][3:0] LETTER_PAT =
    {PAT_H, PAT_G, PAT_F, PAT_E, PAT_D, PAT_C, PAT_B, PAT_A};

  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int LETTER_GAP_UNITS = 3;
  localparam int MAX_SYMBOLS      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/morse_decoder_lookup.sv
// morse_lookup: combinational map from an assembled symbol group to a letter.
//   len   in  [2:0]  number of valid symbols (0..4)
//   sym   in  [3:0]  symbol shift register; the last symbol is in bit 0
//   code  out [2:0]  letter code; only meaningful when match = 1
//   match out        1 when (len, sym[len-1:0]) is a known letter
module morse_lookup
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [3:0] sym,
  output logic [2:0] code,
  output logic       match
);

  logic [4:0] one_hot;
  logic [3:0] mask;
  logic [3:0] sym_masked;

  // Keep only the low len bits of sym. For len = 4, one_hot[3:0] is 0 and
  // subtracting 1 wraps to 1111.
  assign one_hot    = 5'd1 << len;
  assign mask       = one_hot[3:0] - 4'd1;
  assign sym_masked = sym & mask;

  always_comb begin
    code  = 3'd0;
    match = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!match && len == LETTER_LEN[i] && sym_masked == LETTER_PAT[i]) begin
        code  = 3'(i);
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: decodes a serial dot/dash line into letters A..H.
// The line is sampled once per Enable tick. Mark and space run lengths are
// measured and each mark is classified as a dot or a dash. Up to four symbols
// are assembled. An inter-letter gap of LETTER_GAP spaces ends the letter and
// reports the decoded letter or an error.
//   Clock       in        system clock; all state changes on posedge
//   Reset       in        synchronous, active-low reset
//   Enable      in        one-cycle unit tick; DotDashIn is sampled only when high
//   DotDashIn   in        serial line; 1 = mark, 0 = space
//   Letter      out [2:0] last decoded letter code (A = 000)
//   LetterValid out       one-cycle pulse when Letter is updated
//   Error       out       one-cycle pulse when a malformed or unknown letter ends
//   Busy        out       high whenever the FSM is not idle
module morse_decoder
  import morse_pkg::*;
#(
  parameter int LETTER_GAP = LETTER_GAP_UNITS,
  parameter int RUN_W      = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       DotDashIn,
  output logic [2:0] Letter,
  output logic       LetterValid,
  output logic       Error,
  output logic       Busy
);

  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_DOT    = RUN_W'(DOT_UNITS);
  localparam logic [RUN_W-1:0] RUN_DASH   = RUN_W'(DASH_UNITS);
  // A mark one unit longer than a dash can never become valid.
  localparam logic [RUN_W-1:0] RUN_TOOLONG = RUN_W'(DASH_UNITS + 1);
  localparam logic [RUN_W-1:0] RUN_GAP    = RUN_W'(LETTER_GAP);
  localparam logic [2:0]       LEN_MAX    = 3'(MAX_SYMBOLS);

  state_t           state_reg, state_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic [2:0]       len_reg, len_next;
  logic [3:0]       sym_reg, sym_next;
  logic [2:0]       letter_reg, letter_next;
  logic             valid_reg, valid_next;
  logic             error_reg, error_next;

  logic [RUN_W-1:0] run_inc;
  logic [2:0]       lookup_code;
  logic             lookup_match;

  // The run counter saturates instead of wrapping.
  assign run_inc = (run_reg == '1) ? run_reg : run_reg + 1'b1;

  morse_lookup u_lookup (
    .len   (len_reg),
    .sym   (sym_reg),
    .code  (lookup_code),
    .match (lookup_match)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg  <= ST_IDLE;
      run_reg    <= '0;
      len_reg    <= 3'd0;
      sym_reg    <= 4'd0;
      letter_reg <= LTR_A;
      valid_reg  <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      run_reg    <= run_next;
      len_reg    <= len_next;
      sym_reg    <= sym_next;
      letter_reg <= letter_next;
      valid_reg  <= valid_next;
      error_reg  <= error_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    run_next    = run_reg;
    len_next    = len_reg;
    sym_next    = sym_reg;
    letter_next = letter_reg;
    valid_next  = 1'b0;
    error_next  = 1'b0;

    if (Enable) begin
      case (state_reg)
        ST_IDLE: begin
          if (DotDashIn) begin
            state_next = ST_MARK;
            run_next   = RUN_ONE;
          end
        end

        ST_MARK: begin
          if (DotDashIn) begin
            if (run_inc == RUN_TOOLONG) begin
              state_next = ST_ERR;
              run_next   = '0;
            end else begin
              run_next = run_inc;
            end
          end else if ((run_reg == RUN_DOT || run_reg == RUN_DASH) && len_reg != LEN_MAX) begin
            sym_next   = {sym_reg[2:0], run_reg == RUN_DASH};
            len_next   = len_reg + 3'd1;
            state_next = ST_SPACE;
            run_next   = RUN_ONE;
          end else begin
            // A bad mark length or a fifth symbol. The space just sampled
            // already counts toward the terminating gap.
            state_next = ST_ERR;
            run_next   = RUN_ONE;
          end
        end

        ST_SPACE: begin
          if (DotDashIn) begin
            state_next = ST_MARK;
            run_next   = RUN_ONE;
          end else begin
            run_next = run_inc;
            if (run_inc == RUN_GAP) begin
              if (lookup_match) begin
                letter_next = lookup_code;
                valid_next  = 1'b1;
              end else begin
                error_next = 1'b1;
              end
              state_next = ST_IDLE;
              run_next   = '0;
              len_next   = 3'd0;
              sym_next   = 4'd0;
            end
          end
        end

        ST_ERR: begin
          if (DotDashIn) begin
            run_next = '0;
          end else begin
            run_next = run_inc;
            if (run_inc == RUN_GAP) begin
              error_next = 1'b1;
              state_next = ST_IDLE;
              run_next   = '0;
              len_next   = 3'd0;
              sym_next   = 4'd0;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign Letter      = letter_reg;
  assign LetterValid = valid_reg;
  assign Error       = error_reg;
  assign Busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed stimulus for morse_decoder with a scoreboard.
// The stimulus pushes the expected pulse (kind, Letter, due cycle) when it
// drives the last space of a letter. A monitor pops and compares on every
// LetterValid or Error pulse.
module tb_morse_decoder;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       dot_dash_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       error;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [2:0] letter;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle_cnt = 0;
  logic [2:0] model_letter = 3'd0;

  morse_decoder dut (
    .Clock       (clock),
    .Reset       (reset),
    .Enable      (enable),
    .DotDashIn   (dot_dash_in),
    .Letter      (letter),
    .LetterValid (letter_valid),
    .Error       (error),
    .Busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Drive n units, MSB first. One unit per 4 clocks, and Enable is high in the
  // first cycle of each unit. When pulse is set, push the expected pulse while
  // driving the last unit. It is due right after the next posedge.
  task automatic send_seq(input logic [31:0] bits, input int n, input bit pulse,
                          input bit is_err, input logic [2:0] code);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clock);
      enable      = 1'b1;
      dot_dash_in = bits[i];
      if (i == 0 && pulse) begin
        exp_q.push_back('{is_err, is_err ? model_letter : code, cycle_cnt + 1});
        if (!is_err) model_letter = code;
      end
      @(negedge clock);
      enable = 1'b0;
      repeat (2) @(negedge clock);
    end
  endtask

  // Monitor: compare every output pulse against the scoreboard.
  always @(negedge clock) begin
    if (letter_valid || error) begin
      exp_t e;
      check("valid_and_error_exclusive", {31'd0, letter_valid & error}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, letter_valid, error}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("pulse: valid=%0d error=%0d letter=%0d cycle=%0d (expect err=%0d letter=%0d cycle=%0d)",
                 letter_valid, error, letter, cycle_cnt, e.is_err, e.letter, e.due);
        check("pulse_error", {31'd0, error}, {31'd0, e.is_err});
        check("pulse_valid", {31'd0, letter_valid}, {31'd0, !e.is_err});
        check("pulse_letter", {29'd0, letter}, {29'd0, e.letter});
        check("pulse_cycle", cycle_cnt, e.due);
        check("busy_falls_with_pulse", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    dot_dash_in = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_letter", {29'd0, letter}, 32'd0);
    check("reset_valid", {31'd0, letter_valid}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Idle spaces must produce nothing.
    send_seq(32'b000000, 6, 0, 0, 3'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    send_seq(32'b10111000, 8, 1, 0, 3'd0);         // A
    send_seq(32'b1010101000, 10, 1, 0, 3'd7);      // H
    send_seq(32'b1000, 4, 1, 0, 3'd4);             // E
    send_seq(32'b11000, 5, 1, 1, 3'd0);            // 2-unit mark
    send_seq(32'b1111000, 7, 1, 1, 3'd0);          // 4-unit mark
    send_seq(32'b101010101000, 12, 1, 1, 3'd0);    // five dots
    send_seq(32'b111000, 6, 1, 1, 3'd0);           // lone dash, unknown

    // D with a long Enable-low hold in the middle.
    send_seq(32'b111010, 6, 0, 0, 3'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      enable      = 1'b0;
      dot_dash_in = ~dot_dash_in;
      check("hold_busy", {31'd0, busy}, 32'd1);
    end
    send_seq(32'b1000, 4, 1, 0, 3'd3);             // finishes D

    // Reset in the middle of B's dash.
    send_seq(32'b11, 2, 0, 0, 3'd0);
    check("busy_mid_dash", {31'd0, busy}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_letter = 3'd0;
    check("midreset_letter", {29'd0, letter}, 32'd0);
    check("midreset_valid", {31'd0, letter_valid}, 32'd0);
    check("midreset_error", {31'd0, error}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    send_seq(32'b000, 3, 0, 0, 3'd0);
    send_seq(32'b11101011101000, 14, 1, 0, 3'd2);  // C

    repeat (8) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("final_letter", {29'd0, letter}, {29'd0, model_letter});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
